sumador_restador_secuencial: RTL and testbench

Parametrised multi-cycle adder/subtractor, successor to the 3-bit combinational subtractor. It processes operands CHUNK bits per clock from the LSB with a start/busy/done handshake. It supports add and subtract modes, signed and unsigned flag interpretation, and optional saturation. It sits between operand registers and result consumers in the arithmetic datapath, where a narrow carry chain per cycle is preferred over a full-width one.

---
 rtl/sumador_restador_secuencial.sv | 219 +++++++++++++++++++++
 tb/tb_sumador_restador_secuencial.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sumador_restador_secuencial.sv
// -----------------------------------------------------------------------------
// sumador_restador_secuencial
//
// Multi-cycle adder/subtractor. Operands are consumed CHUNK bits per clock,
// LSB first. A narrow carry chain per cycle replaces a full-width one.
// Subtraction is computed as a + ~b + 1 by seeding the carry with op.
//
// Parameters:
//   WIDTH    operand/result width (>= 2)
//   CHUNK    bits processed per cycle (WIDTH must be a multiple of CHUNK)
//   SATURATE 1 clamps the result on overflow, 0 wraps modulo 2^WIDTH
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled on the rising edge while idle
//   op           0 = a + b, 1 = a - b
//   signed_mode  1 = two's-complement overflow/saturation semantics
//   a, b         operands, latched when start is accepted
//   busy         computation in progress
//   done         one-cycle completion pulse
//   res          result, held until the next completion
//   carry        add: carry out; sub: borrow (a < b unsigned)
//   overflow     unsigned: same as carry; signed: two's-complement overflow
//   zero         res == 0 (after saturation)
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last completed result
// CALC  | one chunk per edge; results published on the last chunk edge
// -----------------------------------------------------------------------------
module sumador_restador_secuencial #(
  parameter int WIDTH    = 8,
  parameter int CHUNK    = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("sumador_restador_secuencial: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               op_q, op_d;
  logic               sm_q, sm_d;
  logic               a_msb_q, a_msb_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK-1:0]   sum_chunk;
  logic               c_out;
  logic               c_msb;
  logic [WIDTH-1:0]   full_res;
  logic               carry_flag;
  logic               ovf_flag;
  logic [WIDTH-1:0]   sat_res;
  logic [WIDTH-1:0]   final_res;

  // Operand registers shift right, so the active chunk is always at the bottom.
  assign a_chunk = a_q[CHUNK-1:0];
  assign b_chunk = b_q[CHUNK-1:0] ^ {CHUNK{op_q}};
  assign {c_out, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};

  // Carry into the top bit recovered from that bit's sum: cin = a ^ b ^ s.
  assign c_msb = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum_chunk[CHUNK-1];

  // New chunk enters at the top; after N shifts acc holds the full result.
  assign full_res = (acc_q >> CHUNK) | (WIDTH'(sum_chunk) << (WIDTH - CHUNK));

  assign carry_flag = op_q ? ~c_out : c_out;
  assign ovf_flag   = sm_q ? (c_msb ^ c_out) : carry_flag;

  always_comb begin
    sat_res = '0;
    if (sm_q) begin
      sat_res = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat_res = op_q ? '0 : '1;
    end
  end

  assign final_res = (SATURATE && ovf_flag) ? sat_res : full_res;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    sm_d       = sm_q;
    a_msb_d    = a_msb_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    res_d      = res_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          sm_d    = signed_mode;
          a_msb_d = a[WIDTH-1];
          c_d     = op;
          cnt_d   = CNT_LAST;
          acc_d   = '0;
          state_d = CALC;
          busy_d  = 1'b1;
        end
      end

      CALC: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        c_d   = c_out;
        acc_d = full_res;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          res_d      = final_res;
          carry_d    = carry_flag;
          overflow_d = ovf_flag;
          zero_d     = (final_res == '0);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      sm_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      c_q        <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      sm_q       <= sm_d;
      a_msb_q    <= a_msb_d;
      c_q        <= c_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res      = res_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_sumador_restador_secuencial.sv
module tb_sumador_restador_secuencial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       op_in = 1'b0;
  logic       sm_in = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;

  logic       busy8, done8, carry8, ovf8, zero8;
  logic [7:0] res8;
  logic       busy8s, done8s, carry8s, ovf8s, zero8s;
  logic [7:0] res8s;
  logic       busy3, done3, carry3, ovf3, zero3;
  logic [2:0] res3;

  logic [7:0] e_res8, e_res8s, e_res3;
  logic       e_c8, e_ov8, e_z8, e_c8s, e_ov8s, e_z8s, e_c3, e_ov3, e_z3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sumador_restador_secuencial #(.WIDTH(8), .CHUNK(2), .SATURATE(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_in), .signed_mode(sm_in),
    .a(a_in), .b(b_in), .busy(busy8), .done(done8), .res(res8),
    .carry(carry8), .overflow(ovf8), .zero(zero8));

  sumador_restador_secuencial #(.WIDTH(8), .CHUNK(2), .SATURATE(1'b1)) dut8s (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_in), .signed_mode(sm_in),
    .a(a_in), .b(b_in), .busy(busy8s), .done(done8s), .res(res8s),
    .carry(carry8s), .overflow(ovf8s), .zero(zero8s));

  sumador_restador_secuencial #(.WIDTH(3), .CHUNK(1), .SATURATE(1'b0)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_in), .signed_mode(sm_in),
    .a(a_in[2:0]), .b(b_in[2:0]), .busy(busy3), .done(done3), .res(res3),
    .carry(carry3), .overflow(ovf3), .zero(zero3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input int w, input bit sat, input logic [7:0] a,
                                input logic [7:0] b, input logic op, input logic sm,
                                output logic [7:0] r, output logic c, output logic ov,
                                output logic z);
    longint m  = longint'(1) << w;
    longint ua = longint'(a) % m;
    longint ub = longint'(b) % m;
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint ur = op ? ua - ub : ua + ub;
    longint sr = op ? sa - sb : sa + sb;
    longint rr;
    c  = op ? (ua < ub) : (ur >= m);
    ov = sm ? ((sr < -(m / 2)) || (sr > m / 2 - 1)) : c;
    rr = ((ur % m) + m) % m;
    if (sat && ov) begin
      if (sm) rr = (sa < 0) ? m / 2 : m / 2 - 1;
      else    rr = op ? 0 : m - 1;
    end
    r = rr[7:0];
    z = (rr == 0);
  endfunction

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic op,
                          input logic sm);
    @(negedge clk);
    a_in = a; b_in = b; op_in = op; sm_in = sm; start = 1'b1;
    model(8, 1'b0, a, b, op, sm, e_res8, e_c8, e_ov8, e_z8);
    model(8, 1'b1, a, b, op, sm, e_res8s, e_c8s, e_ov8s, e_z8s);
    model(3, 1'b0, a, b, op, sm, e_res3, e_c3, e_ov3, e_z3);
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs: the latched operands must not follow them.
    a_in = 8'($urandom); b_in = 8'($urandom); op_in = ~op; sm_in = ~sm;
  endtask

  // Walks ncyc edges after the start edge, checking busy and done timing.
  task automatic collect(input int ncyc, input bit noise);
    chk("busy_after_start", busy8, 1'b1);
    for (int k = 1; k <= ncyc; k++) begin
      if (noise && (k == 1 || k == 2)) begin
        start = 1'b1; a_in = 8'($urandom); b_in = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("busy8", busy8, (k < 4));
      chk("done8", done8, (k == 4));
      chk("done8s", done8s, (k == 4));
      chk("done3", done3, (k == 3));
    end
    start = 1'b0;
  endtask

  task automatic check_results();
    chk("res8", res8, e_res8);
    chk("carry8", carry8, e_c8);
    chk("ovf8", ovf8, e_ov8);
    chk("zero8", zero8, e_z8);
    chk("res8s", res8s, e_res8s);
    chk("carry8s", carry8s, e_c8s);
    chk("ovf8s", ovf8s, e_ov8s);
    chk("zero8s", zero8s, e_z8s);
    chk("res3", res3, e_res3);
    chk("carry3", carry3, e_c3);
    chk("ovf3", ovf3, e_ov3);
    chk("zero3", zero3, e_z3);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_res"}, res8, 8'h00);
    chk({tag, "_carry"}, carry8, 1'b0);
    chk({tag, "_ovf"}, ovf8, 1'b0);
    chk({tag, "_zero"}, zero8, 1'b0);
    chk({tag, "_busy"}, busy8, 1'b0);
    chk({tag, "_done"}, done8, 1'b0);
  endtask

  initial begin
    // Reset held over a few edges.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    chk("por_res3", res3, 3'b000);
    chk("por_busy3", busy3, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 200 + 100 unsigned: wraps to 0x2C with carry.
    start_op(8'd200, 8'd100, 1'b0, 1'b0);
    collect(5, 1'b0);
    check_results();
    chk("dir_200p100_res", res8, 8'h2C);

    // Asynchronous reset between edges clears outputs immediately.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 3-bit subtractor cases.
    start_op(8'd5, 8'd4, 1'b1, 1'b0);
    collect(5, 1'b0);
    check_results();
    chk("dir3_5m4_res", res3, 3'b001);
    start_op(8'd4, 8'd5, 1'b1, 1'b0);
    collect(5, 1'b0);
    check_results();
    chk("dir3_4m5_res", res3, 3'b111);
    chk("dir3_4m5_carry", carry3, 1'b1);

    // Signed 0x80 - 0x01: wrap vs saturate.
    start_op(8'h80, 8'h01, 1'b1, 1'b1);
    collect(5, 1'b0);
    check_results();
    chk("sgn_wrap_res", res8, 8'h7F);
    chk("sgn_sat_res", res8s, 8'h80);

    // Starts while busy are ignored.
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    collect(6, 1'b1);
    check_results();

    // Back-to-back start in the done cycle.
    start_op(8'h3C, 8'h0F, 1'b0, 1'b0);
    collect(4, 1'b0);
    check_results();
    start_op(8'h55, 8'h55, 1'b1, 1'b0);
    collect(6, 1'b0);
    check_results();
    chk("b2b_zero", zero8, 1'b1);

    // Reset during CALC aborts with no completion.
    start_op(8'hA5, 8'h5A, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", done8, 1'b0);
    end
    start_op(8'd1, 8'd1, 1'b0, 1'b0);
    collect(6, 1'b0);
    check_results();
    chk("abort_next_res", res8, 8'd2);

    // Randomised operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      start_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      collect(5, (i % 5) == 0);
      check_results();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
